dma_mode_sched: RTL and testbench
=================================

Name: dma_mode_sched

Overview:
- Sequences the DMA copy engine and owns the direction select for the AXI-MM source/destination mux.
- Accepts transfer descriptors from two requesters: HOST_TO_DDR (h2d) and DDR_TO_HOST (d2h).
- Arbitrates between them round-robin and hands one descriptor at a time to the engine.
- Changes the mux `mode` only when the datapath is fully quiesced: engine done, and zero outstanding reads and writes.

Parameters:
- DESC_W, 160, opaque descriptor width (src addr 64, dst addr 64, length 32); passed through unmodified.
- OUTST_W, 8, width of the outstanding-read and outstanding-write counters; max outstanding = 2^OUTST_W-1.

Ports:
- clk  in  1  clock (engine/host_mem clock domain)
- reset  in  1  synchronous, active-high reset
- h2d_desc_valid  in  1  HOST_TO_DDR descriptor offered
- h2d_desc_ready  out  1  HOST_TO_DDR descriptor accepted
- h2d_desc  in  DESC_W  HOST_TO_DDR descriptor
- h2d_done  out  1  one-cycle pulse: h2d descriptor fully drained
- d2h_desc_valid  in  1  DDR_TO_HOST descriptor offered
- d2h_desc_ready  out  1  DDR_TO_HOST descriptor accepted
- d2h_desc  in  DESC_W  DDR_TO_HOST descriptor
- d2h_done  out  1  one-cycle pulse: d2h descriptor fully drained
- eng_desc_valid  out  1  descriptor to engine
- eng_desc_ready  in  1  engine accepts descriptor
- eng_desc  out  DESC_W  descriptor to engine
- eng_done  in  1  one-cycle pulse: engine has issued its last beat
- mode  out  dma_pkg::e_dma_mode  mux direction select
- ar_fire, r_last_fire, aw_fire, b_fire  in  1 each  AXI handshake events on the muxed source/destination ports
- rd_credit_ok, wr_credit_ok  out  1 each  engine may issue AR / AW
- err_underflow  out  1  sticky: a counter decremented at zero

Behaviour:
- Reset values:
  - FSM in IDLE.
  - mode = DDR_TO_HOST.
  - Both counters = 0.
  - All valid, ready and done outputs = 0.
  - rd_credit_ok = wr_credit_ok = 1.
  - err_underflow = 0.
  - RR pointer favours h2d first.
- FSM states and transitions:
  - IDLE:
    - Pick a requester by round-robin among those with valid = 1; the pointer flips only after a grant.
    - If the winner's direction equals `mode`: assert that requester's ready for one cycle, capture its desc into eng_desc, go to ISSUE.
    - Otherwise: update `mode` without accepting the descriptor, go to SETTLE.
  - SETTLE: one cycle so the mux combinational paths see the new mode. Return to IDLE; the same requester is guaranteed the grant (pointer not advanced).
  - ISSUE:
    - eng_desc_valid = 1; eng_desc is held stable until eng_desc_ready.
    - On the handshake, go to BUSY.
    - If eng_done arrives in the same cycle as the handshake, go directly to DRAIN.
  - BUSY: wait for eng_done, then go to DRAIN.
  - DRAIN:
    - Wait until rd_cnt == 0 and wr_cnt == 0.
    - Then pulse h2d_done or d2h_done for exactly 1 cycle (matching the granted direction) and go to IDLE.
    - Minimum latency from eng_done to the done pulse is 1 cycle.
- Counter rules:
  - rd_cnt += ar_fire, −= r_last_fire; wr_cnt += aw_fire, −= b_fire.
  - Simultaneous increment and decrement leaves the count unchanged.
- Credits:
  - rd_credit_ok = (rd_cnt != max); wr_credit_ok = (wr_cnt != max).
  - A fire event while a counter is at max is ignored (counter saturates).
- Underflow: a decrement at 0 leaves the counter at 0 and sets err_underflow; it clears only on reset.
- mode never changes outside IDLE → SETTLE. This rule holds even if a requester withdraws valid during SETTLE; the block then returns to IDLE with the new mode kept.
- h2d_desc_ready and d2h_desc_ready are never asserted together. Ready is never asserted in any state other than IDLE.
- Reset mid-operation:
  - Drops eng_desc_valid immediately.
  - Zeroes the counters and returns the FSM to IDLE with mode = DDR_TO_HOST.
  - No done pulse is issued for the aborted descriptor.

Optional Feature:
- Macro: DMA_MODE_SCHED_STATS_EN.
- When defined, the block adds these output ports, all cleared by reset:
  - h2d_desc_cnt, d2h_desc_cnt (32 bits each): increment on every done pulse and wrap at 2^32.
  - mode_switch_cnt (16 bits): increments on each SETTLE entry and saturates.
  - drain_cycles (32 bits): cycles spent in DRAIN; saturates.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single h2d desc, no d2h traffic:
  - After reset → one SETTLE cycle; mode = HOST_TO_DDR.
  - eng_desc equals h2d_desc.
  - 4 ar_fire / 4 r_last_fire / 4 aw_fire / 4 b_fire followed by eng_done → h2d_done pulses once, 1 cycle after the last b_fire.
- h2d and d2h valid continuously:
  - Grants alternate h2d, d2h, h2d.
  - Every grant is preceded by exactly one SETTLE cycle; no ready is asserted while either counter is nonzero.
- Drain hold:
  - eng_done arrives while rd_cnt = 3 and wr_cnt = 2 → FSM stays in DRAIN.
  - The done pulse appears only in the cycle after the last b_fire / r_last_fire brings both counters to 0.
- Counter edge cases:
  - Simultaneous ar_fire and r_last_fire at rd_cnt = 5 → rd_cnt stays 5.
  - Driving 255 ar_fire with OUTST_W = 8 → rd_credit_ok = 0; a 256th ar_fire leaves rd_cnt = 255.
  - r_last_fire at rd_cnt = 0 → err_underflow = 1 until reset.
- Engine backpressure: hold eng_desc_ready = 0 for 10 cycles → eng_desc_valid stays 1 and eng_desc stays stable; the handshake on cycle 11 moves the FSM to BUSY.
- Reset during BUSY with rd_cnt = 4:
  - Next cycle: mode = DDR_TO_HOST, counters = 0, no done pulse.
  - A new d2h desc is then accepted without a SETTLE cycle.

Source files
------------

// File: rtl/dma_mode_sched.sv
// DMA mode scheduler: round-robin arbitration of h2d/d2h descriptors, switching the mux mode only when quiesced.
// Optional statistics ports are enabled by defining DMA_MODE_SCHED_STATS_EN.

package dma_pkg;
  typedef enum logic {DDR_TO_HOST = 1'b0, HOST_TO_DDR = 1'b1} e_dma_mode;
endpackage

module dma_mode_sched #(
  parameter int DESC_W  = 160,
  parameter int OUTST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               h2d_desc_valid,
  output logic               h2d_desc_ready,
  input  logic [DESC_W-1:0]  h2d_desc,
  output logic               h2d_done,
  input  logic               d2h_desc_valid,
  output logic               d2h_desc_ready,
  input  logic [DESC_W-1:0]  d2h_desc,
  output logic               d2h_done,
  output logic               eng_desc_valid,
  input  logic               eng_desc_ready,
  output logic [DESC_W-1:0]  eng_desc,
  input  logic               eng_done,
  output dma_pkg::e_dma_mode mode,
  input  logic               ar_fire,
  input  logic               r_last_fire,
  input  logic               aw_fire,
  input  logic               b_fire,
  output logic               rd_credit_ok,
  output logic               wr_credit_ok,
  output logic               err_underflow
`ifdef DMA_MODE_SCHED_STATS_EN
  ,
  output logic [31:0]        h2d_desc_cnt,
  output logic [31:0]        d2h_desc_cnt,
  output logic [15:0]        mode_switch_cnt,
  output logic [31:0]        drain_cycles
`endif
);
  import dma_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ISSUE, S_BUSY, S_DRAIN} state_t;

  localparam logic [OUTST_W-1:0] CNT_MAX = '1;
  localparam logic [OUTST_W-1:0] CNT_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic              pend_vld, pend_h2d;
  logic              any_req, win_h2d, grant, switch_req, drained;
  e_dma_mode         win_mode;
  logic [OUTST_W-1:0] rd_cnt, wr_cnt;

  // Winner selection; a requester that caused a mode switch keeps priority on the following IDLE cycle.
  always_comb begin
    any_req = h2d_desc_valid | d2h_desc_valid;
    win_h2d = 1'b0;
    if (pend_vld && (pend_h2d ? h2d_desc_valid : d2h_desc_valid))
      win_h2d = pend_h2d;
    else if (h2d_desc_valid && d2h_desc_valid)
      win_h2d = ~rr_ptr;
    else
      win_h2d = h2d_desc_valid;
    win_mode   = win_h2d ? HOST_TO_DDR : DDR_TO_HOST;
    grant      = (state == S_IDLE) && any_req && (win_mode == mode);
    switch_req = (state == S_IDLE) && any_req && (win_mode != mode);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant)           state_nxt = S_ISSUE;
        else if (switch_req) state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_IDLE;
      S_ISSUE: begin
        if (eng_desc_ready) state_nxt = eng_done ? S_DRAIN : S_BUSY;
      end
      S_BUSY: begin
        if (eng_done) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_cnt == '0 && wr_cnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Mode stays fixed for the whole transfer, so it also identifies which requester gets the done pulse.
  always_comb begin
    h2d_desc_ready = grant & win_h2d;
    d2h_desc_ready = grant & ~win_h2d;
    eng_desc_valid = (state == S_ISSUE);
    drained        = (state == S_DRAIN) && (rd_cnt == '0) && (wr_cnt == '0);
    h2d_done       = drained && (mode == HOST_TO_DDR);
    d2h_done       = drained && (mode == DDR_TO_HOST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= DDR_TO_HOST;
      rr_ptr   <= 1'b0;
      pend_vld <= 1'b0;
      pend_h2d <= 1'b0;
      eng_desc <= '0;
    end else begin
      if (state == S_IDLE) begin
        pend_vld <= switch_req;
        if (switch_req) begin
          pend_h2d <= win_h2d;
          mode     <= win_mode;
        end
      end
      if (grant) begin
        rr_ptr   <= win_h2d;
        eng_desc <= win_h2d ? h2d_desc : d2h_desc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
    end else if (ar_fire && !r_last_fire) begin
      if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + CNT_ONE;
    end else if (r_last_fire && !ar_fire) begin
      if (rd_cnt != '0) rd_cnt <= rd_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
    end else if (aw_fire && !b_fire) begin
      if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + CNT_ONE;
    end else if (b_fire && !aw_fire) begin
      if (wr_cnt != '0) wr_cnt <= wr_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_underflow <= 1'b0;
    else if ((r_last_fire && !ar_fire && rd_cnt == '0) || (b_fire && !aw_fire && wr_cnt == '0))
      err_underflow <= 1'b1;
  end

  assign rd_credit_ok = (rd_cnt != CNT_MAX);
  assign wr_credit_ok = (wr_cnt != CNT_MAX);

`ifdef DMA_MODE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      h2d_desc_cnt    <= '0;
      d2h_desc_cnt    <= '0;
      mode_switch_cnt <= '0;
      drain_cycles    <= '0;
    end else begin
      if (h2d_done) h2d_desc_cnt <= h2d_desc_cnt + 32'd1;
      if (d2h_done) d2h_desc_cnt <= d2h_desc_cnt + 32'd1;
      if (switch_req && mode_switch_cnt != 16'hFFFF) mode_switch_cnt <= mode_switch_cnt + 16'd1;
      if (state == S_DRAIN && drain_cycles != 32'hFFFF_FFFF) drain_cycles <= drain_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_mode_sched.sv
// Randomized and directed bench for dma_mode_sched against a transaction-level reference model.

module tb_dma_mode_sched;
  import dma_pkg::*;

  localparam int DW   = 160;
  localparam int CMAX = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic h2d_desc_valid, h2d_desc_ready, h2d_done;
  logic d2h_desc_valid, d2h_desc_ready, d2h_done;
  logic [DW-1:0] h2d_desc, d2h_desc, eng_desc;
  logic eng_desc_valid, eng_desc_ready, eng_done;
  e_dma_mode mode;
  logic ar_fire, r_last_fire, aw_fire, b_fire;
  logic rd_credit_ok, wr_credit_ok, err_underflow;

  dma_mode_sched #(.DESC_W(DW), .OUTST_W(8)) dut (
    .clk(clk), .reset(reset),
    .h2d_desc_valid(h2d_desc_valid), .h2d_desc_ready(h2d_desc_ready), .h2d_desc(h2d_desc), .h2d_done(h2d_done),
    .d2h_desc_valid(d2h_desc_valid), .d2h_desc_ready(d2h_desc_ready), .d2h_desc(d2h_desc), .d2h_done(d2h_done),
    .eng_desc_valid(eng_desc_valid), .eng_desc_ready(eng_desc_ready), .eng_desc(eng_desc), .eng_done(eng_done),
    .mode(mode),
    .ar_fire(ar_fire), .r_last_fire(r_last_fire), .aw_fire(aw_fire), .b_fire(b_fire),
    .rd_credit_ok(rd_credit_ok), .wr_credit_ok(wr_credit_ok), .err_underflow(err_underflow)
  );

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference model: outstanding counts, current transfer, and arbitration bookkeeping.
  e_dma_mode mode_m;
  int rd_m, wr_m;
  bit err_m, busy_m, settle_m, lock_m, lock_h2d, favour_h2d;
  bit eng_pend_m, handed_m, done_seen_m, cur_h2d;
  logic [DW-1:0] cur_desc;
  int h2d_done_obs = 0, d2h_done_obs = 0, h2d_done_exp = 0, d2h_done_exp = 0;
  int grant_total = 0;
  bit keep_h2d = 0, keep_d2h = 0;
  int grant_log[$];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] randDesc();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic modelReset();
    mode_m = DDR_TO_HOST; rd_m = 0; wr_m = 0; err_m = 0;
    busy_m = 0; settle_m = 0; lock_m = 0; lock_h2d = 0; favour_h2d = 1;
    eng_pend_m = 0; handed_m = 0; done_seen_m = 0; cur_h2d = 0;
  endtask

  // Drives one cycle of inputs (called at a negedge), checks outputs mid-cycle, then advances the model.
  task automatic applyStimulus(input logic [3:0] fire, input logic e_rdy, input logic e_done, input logic rst);
    bit want_h2d, want_d2h, sw, exp_done, w_valid, w_h2d, idle_now, g_h2d, g_d2h, inc, dec;
    reset = rst;
    {ar_fire, r_last_fire, aw_fire, b_fire} = fire;
    eng_desc_ready = e_rdy;
    eng_done = e_done;
    #2;
    if (h2d_done) h2d_done_obs++;
    if (d2h_done) d2h_done_obs++;
    if (rst) begin
      @(negedge clk);
      modelReset();
      return;
    end
    g_h2d = h2d_desc_ready && h2d_desc_valid;
    g_d2h = d2h_desc_ready && d2h_desc_valid;
    if (g_h2d || g_d2h) begin
      grant_total++;
      grant_log.push_back(g_h2d ? 1 : 0);
    end

    want_h2d = 0; want_d2h = 0; sw = 0; w_valid = 0; w_h2d = 0;
    idle_now = !busy_m && !settle_m;
    if (idle_now) begin
      if (lock_m && (lock_h2d ? h2d_desc_valid : d2h_desc_valid)) begin
        w_valid = 1; w_h2d = lock_h2d;
      end else if (h2d_desc_valid && d2h_desc_valid) begin
        w_valid = 1; w_h2d = favour_h2d;
      end else if (h2d_desc_valid || d2h_desc_valid) begin
        w_valid = 1; w_h2d = h2d_desc_valid;
      end
      if (w_valid) begin
        if ((w_h2d ? HOST_TO_DDR : DDR_TO_HOST) == mode_m) begin
          want_h2d = w_h2d; want_d2h = !w_h2d;
        end else sw = 1;
      end
    end
    exp_done = busy_m && handed_m && done_seen_m && rd_m == 0 && wr_m == 0;

    checkOutput("mode", 160'(mode), 160'(mode_m));
    checkOutput("h2d_ready", 160'(h2d_desc_ready), 160'(want_h2d));
    checkOutput("d2h_ready", 160'(d2h_desc_ready), 160'(want_d2h));
    checkOutput("eng_valid", 160'(eng_desc_valid), 160'(eng_pend_m));
    if (eng_pend_m) checkOutput("eng_desc", eng_desc, cur_desc);
    checkOutput("h2d_done", 160'(h2d_done), 160'(exp_done && cur_h2d));
    checkOutput("d2h_done", 160'(d2h_done), 160'(exp_done && !cur_h2d));
    checkOutput("rd_credit", 160'(rd_credit_ok), 160'(rd_m != CMAX));
    checkOutput("wr_credit", 160'(wr_credit_ok), 160'(wr_m != CMAX));
    checkOutput("err_underflow", 160'(err_underflow), 160'(err_m));

    if (exp_done) begin
      busy_m = 0; handed_m = 0; done_seen_m = 0;
      if (cur_h2d) h2d_done_exp++; else d2h_done_exp++;
    end
    if (eng_pend_m && e_rdy) begin
      eng_pend_m = 0; handed_m = 1;
      if (e_done) done_seen_m = 1;
    end else if (busy_m && handed_m && e_done) done_seen_m = 1;
    if (want_h2d || want_d2h) begin
      busy_m = 1; eng_pend_m = 1; cur_h2d = want_h2d;
      cur_desc = want_h2d ? h2d_desc : d2h_desc;
      favour_h2d = !want_h2d; lock_m = 0;
    end else if (sw) begin
      mode_m = w_h2d ? HOST_TO_DDR : DDR_TO_HOST;
      settle_m = 1; lock_m = 1; lock_h2d = w_h2d;
    end else if (settle_m) settle_m = 0;
    else if (idle_now) lock_m = 0;

    inc = fire[3] && !fire[2]; dec = fire[2] && !fire[3];
    if (inc && rd_m < CMAX) rd_m++;
    if (dec) begin if (rd_m == 0) err_m = 1; else rd_m--; end
    inc = fire[1] && !fire[0]; dec = fire[0] && !fire[1];
    if (inc && wr_m < CMAX) wr_m++;
    if (dec) begin if (wr_m == 0) err_m = 1; else wr_m--; end

    @(negedge clk);
    if (g_h2d) begin
      if (keep_h2d) h2d_desc = randDesc(); else h2d_desc_valid = 1'b0;
    end
    if (g_d2h) begin
      if (keep_d2h) d2h_desc = randDesc(); else d2h_desc_valid = 1'b0;
    end
  endtask

  task automatic resetDut();
    repeat (2) applyStimulus(4'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Waits for a new grant and its engine handshake, holding eng_desc_ready low for bp offered cycles.
  task automatic waitGrant(input int bp, input bit done_hs);
    int g0 = grant_total;
    int pend_cyc = 0;
    int guard = 0;
    bit r;
    while (!(grant_total > g0 && handed_m) && guard < 200) begin
      r = eng_pend_m && (pend_cyc >= bp);
      if (eng_pend_m) pend_cyc++;
      applyStimulus(4'b0, r, r && done_hs, 1'b0);
      guard++;
    end
    checkOutput("grant_timeout", 160'(guard < 200), 160'(1));
  endtask

  task automatic finishXfer();
    int guard = 0;
    while (busy_m && guard < 50) begin
      applyStimulus(4'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("drain_timeout", 160'(guard < 50), 160'(1));
  endtask

  task automatic doXfer(input int n_rd, input int n_wr, input int hold, input int bp, input bit done_hs);
    int n_max = (n_rd > n_wr) ? n_rd : n_wr;
    waitGrant(bp, done_hs);
    if (!done_hs) begin
      for (int i = 0; i < n_max; i++) applyStimulus({i < n_rd, 1'b0, i < n_wr, 1'b0}, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0, 1'b1, 1'b1, 1'b0);
      repeat (hold) applyStimulus(4'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < n_max; i++) applyStimulus({1'b0, i < n_rd, 1'b0, i < n_wr}, 1'b1, 1'b0, 1'b0);
    end
    finishXfer();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int g0;
    int h0;
    bit rdy, dn;
    logic [3:0] f;
    reset = 1'b1; h2d_desc_valid = 0; d2h_desc_valid = 0; h2d_desc = '0; d2h_desc = '0;
    eng_desc_ready = 0; eng_done = 0; ar_fire = 0; r_last_fire = 0; aw_fire = 0; b_fire = 0;
    modelReset();
    @(negedge clk);
    resetDut();
    repeat (2) applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);

    // Single h2d descriptor from reset: one settle cycle, then a 4-beat transfer.
    d0 = h2d_done_obs;
    h2d_desc = randDesc(); h2d_desc_valid = 1'b1;
    doXfer(4, 4, 0, 0, 0);
    checkOutput("single_h2d_done_count", 160'(h2d_done_obs - d0), 160'(1));

    // Continuous traffic on both sides alternates grants starting with h2d.
    resetDut();
    grant_log.delete();
    keep_h2d = 1; keep_d2h = 1;
    h2d_desc = randDesc(); d2h_desc = randDesc();
    h2d_desc_valid = 1'b1; d2h_desc_valid = 1'b1;
    doXfer(2, 1, 0, 0, 0);
    doXfer(1, 2, 0, 0, 0);
    keep_h2d = 0; keep_d2h = 0;
    doXfer(1, 1, 0, 0, 0);
    d2h_desc_valid = 1'b0;
    checkOutput("alt_grant_count", 160'(grant_log.size()), 160'(3));
    if (grant_log.size() == 3) begin
      checkOutput("alt_grant0_h2d", 160'(grant_log[0]), 160'(1));
      checkOutput("alt_grant1_d2h", 160'(grant_log[1]), 160'(0));
      checkOutput("alt_grant2_h2d", 160'(grant_log[2]), 160'(1));
    end

    // Drain hold: done waits for rd=3/wr=2 to empty after eng_done.
    resetDut();
    d0 = d2h_done_obs;
    d2h_desc = randDesc(); d2h_desc_valid = 1'b1;
    doXfer(3, 2, 4, 0, 0);
    checkOutput("drain_done_count", 160'(d2h_done_obs - d0), 160'(1));

    // Counter saturation, simultaneous inc/dec, and sticky underflow.
    resetDut();
    repeat (255) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_credit_at_max", 160'(rd_credit_ok), 160'(0));
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    repeat (255) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_sat_no_underflow", 160'(err_underflow), 160'(0));
    repeat (5) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_hold5_no_underflow", 160'(err_underflow), 160'(0));
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_underflow_sticky", 160'(err_underflow), 160'(1));
    resetDut();
    checkOutput("underflow_cleared", 160'(err_underflow), 160'(0));
    repeat (256) applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    checkOutput("wr_credit_at_max", 160'(wr_credit_ok), 160'(0));
    repeat (255) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("wr_underflow", 160'(err_underflow), 160'(1));

    // Engine backpressure for 10 cycles, then a same-cycle handshake and eng_done.
    resetDut();
    h2d_desc = randDesc(); h2d_desc_valid = 1'b1;
    doXfer(2, 2, 0, 10, 0);
    d2h_desc = randDesc(); d2h_desc_valid = 1'b1;
    doXfer(0, 0, 0, 0, 1);

    // Reset while busy with rd=4: no done pulse, then d2h accepted without settling.
    resetDut();
    h2d_desc = randDesc(); h2d_desc_valid = 1'b1;
    waitGrant(0, 0);
    repeat (4) applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    d0 = d2h_done_obs; h0 = h2d_done_obs;
    applyStimulus(4'b0, 1'b0, 1'b0, 1'b1);
    d2h_desc = randDesc(); d2h_desc_valid = 1'b1;
    g0 = grant_total;
    applyStimulus(4'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_grant_no_settle", 160'(grant_total - g0), 160'(1));
    applyStimulus(4'b0, 1'b1, 1'b1, 1'b0);
    finishXfer();
    checkOutput("reset_no_h2d_done", 160'(h2d_done_obs - h0), 160'(0));
    checkOutput("reset_d2h_done", 160'(d2h_done_obs - d0), 160'(1));

    // Randomized traffic.
    resetDut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!h2d_desc_valid && $urandom_range(5) == 0) begin h2d_desc = randDesc(); h2d_desc_valid = 1'b1; end
      if (!d2h_desc_valid && $urandom_range(5) == 0) begin d2h_desc = randDesc(); d2h_desc_valid = 1'b1; end
      rdy = ($urandom_range(1) == 1);
      dn = 0;
      f = 4'b0;
      if (eng_pend_m && rdy && $urandom_range(7) == 0) dn = 1;
      if (busy_m && handed_m && !done_seen_m) begin
        dn = ($urandom_range(4) == 0);
        f[3] = (rd_m < 20) && ($urandom_range(1) == 1);
        f[1] = (wr_m < 20) && ($urandom_range(1) == 1);
      end
      if (busy_m && handed_m) begin
        f[2] = (rd_m > 0) && ($urandom_range(1) == 1);
        f[0] = (wr_m > 0) && ($urandom_range(1) == 1);
      end
      applyStimulus(f, rdy, dn, 1'b0);
    end

    checkOutput("h2d_done_total", 160'(h2d_done_obs), 160'(h2d_done_exp));
    checkOutput("d2h_done_total", 160'(d2h_done_obs), 160'(d2h_done_exp));
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
